// File: rtl/hit_event_generator.sv
// Turns per-pixel collision flags into one-cycle life-event pulses, evaluated once per frame.
// Optional build macro HIT_SHIELD_EN adds a one-hit shield (shield_pickup / shield_active).
//
// state    | meaning
// ---------+------------------------------------------------------------
// ARMED    | vulnerable; enemy, lethal and bonus collisions are evaluated
// COOLDOWN | post-hit invulnerability; sprite blinks, enemy hits ignored
// DEAD     | terminal; all pulses quiet until resetN

module hit_event_generator #(
    parameter int COOLDOWN_FRAMES   = 60,
    parameter int MIN_PIXELS        = 4,
    parameter int BLINK_HALF_PERIOD = 4,
    parameter int MAX_LIVES         = 9
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       collision_enemy,
    input  logic       collision_bonus,
    input  logic       collision_lethal,
    input  logic [3:0] lives_count,
    output logic       hpLoss_trigger,
    output logic       LifeBonus,
    output logic       end_life,
    output logic       invulnerable,
    output logic       blink_visible
`ifdef HIT_SHIELD_EN
    ,
    input  logic       shield_pickup,
    output logic       shield_active
`endif
);

    localparam logic [7:0] CD_LOAD    = 8'(COOLDOWN_FRAMES);
    localparam logic [7:0] MIN_PIX    = 8'(MIN_PIXELS);
    localparam logic [3:0] BLINK_LOAD = 4'(BLINK_HALF_PERIOD);
    localparam logic [3:0] LIVES_MAX  = 4'(MAX_LIVES);

    typedef enum logic [1:0] {ARMED, COOLDOWN, DEAD} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt_enemy, cnt_bonus, cnt_lethal;
    logic [7:0] frame_cnt, frame_cnt_nxt;
    logic [3:0] blink_cnt, blink_cnt_nxt;
    logic       blink_ph, blink_ph_nxt;
    logic       hp_q, hp_nxt, bonus_q, bonus_nxt, end_q, end_nxt;
    logic       enemy_hit, lethal_hit, bonus_ok, hit_absorbed;

    // The flag seen on the startOfFrame cycle already belongs to the new frame.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            cnt_enemy  <= 8'd0;
            cnt_bonus  <= 8'd0;
            cnt_lethal <= 8'd0;
        end else if (startOfFrame) begin
            cnt_enemy  <= {7'd0, collision_enemy};
            cnt_bonus  <= {7'd0, collision_bonus};
            cnt_lethal <= {7'd0, collision_lethal};
        end else begin
            if (collision_enemy  && cnt_enemy  != 8'hFF) cnt_enemy  <= cnt_enemy  + 8'd1;
            if (collision_bonus  && cnt_bonus  != 8'hFF) cnt_bonus  <= cnt_bonus  + 8'd1;
            if (collision_lethal && cnt_lethal != 8'hFF) cnt_lethal <= cnt_lethal + 8'd1;
        end
    end

    assign enemy_hit  = (cnt_enemy >= MIN_PIX);
    assign lethal_hit = (cnt_lethal != 8'd0);
    assign bonus_ok   = (cnt_bonus != 8'd0) && (lives_count < LIVES_MAX);

`ifdef HIT_SHIELD_EN
    logic shield_q, shield_nxt;
    assign hit_absorbed  = shield_q;
    assign shield_active = shield_q;
`else
    assign hit_absorbed = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        frame_cnt_nxt = frame_cnt;
        blink_cnt_nxt = blink_cnt;
        blink_ph_nxt  = blink_ph;
        hp_nxt        = 1'b0;
        bonus_nxt     = 1'b0;
        end_nxt       = 1'b0;
`ifdef HIT_SHIELD_EN
        shield_nxt    = shield_q;
        if (shield_pickup && state != DEAD && !shield_q)
            shield_nxt = 1'b1;
`endif
        if (startOfFrame) begin
            case (state)
                ARMED: begin
                    if (lethal_hit) begin
                        end_nxt   = 1'b1;
                        state_nxt = DEAD;
                    end else if (lives_count == 4'd0) begin
                        state_nxt = DEAD;
                    end else if (enemy_hit) begin
                        hp_nxt        = !hit_absorbed;
`ifdef HIT_SHIELD_EN
                        if (shield_q) shield_nxt = 1'b0;
`endif
                        frame_cnt_nxt = CD_LOAD;
                        blink_cnt_nxt = BLINK_LOAD;
                        blink_ph_nxt  = 1'b0;
                        state_nxt     = COOLDOWN;
                    end else begin
                        bonus_nxt = bonus_ok;
                    end
                end
                COOLDOWN: begin
                    if (lethal_hit) begin
                        end_nxt   = 1'b1;
                        state_nxt = DEAD;
                    end else begin
                        bonus_nxt     = bonus_ok;
                        frame_cnt_nxt = frame_cnt - 8'd1;
                        // Terminal count: this evaluation brings the window to zero.
                        if (frame_cnt == 8'd1) begin
                            state_nxt    = ARMED;
                            blink_ph_nxt = 1'b1;
                        end else if (blink_cnt == 4'd1) begin
                            blink_ph_nxt  = ~blink_ph;
                            blink_cnt_nxt = BLINK_LOAD;
                        end else begin
                            blink_cnt_nxt = blink_cnt - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state     <= ARMED;
            frame_cnt <= 8'd0;
            blink_cnt <= 4'd0;
            blink_ph  <= 1'b1;
            hp_q      <= 1'b0;
            bonus_q   <= 1'b0;
            end_q     <= 1'b0;
`ifdef HIT_SHIELD_EN
            shield_q  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            frame_cnt <= frame_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            blink_ph  <= blink_ph_nxt;
            hp_q      <= hp_nxt;
            bonus_q   <= bonus_nxt;
            end_q     <= end_nxt;
`ifdef HIT_SHIELD_EN
            shield_q  <= shield_nxt;
`endif
        end
    end

    // Gating with resetN keeps a pulse registered just before reset from leaking out.
    assign hpLoss_trigger = hp_q    & resetN;
    assign LifeBonus      = bonus_q & resetN;
    assign end_life       = end_q   & resetN;
    assign invulnerable   = (state == COOLDOWN);
    assign blink_visible  = (state == ARMED) | ((state == COOLDOWN) & blink_ph);

endmodule

// File: tb/tb_hit_event_generator.sv
// Directed bench for hit_event_generator: hits, cooldown/blink, priority, bonus gating, reset.
// Shield scenarios run only when HIT_SHIELD_EN is defined.

module tb_hit_event_generator;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       collision_enemy, collision_bonus, collision_lethal;
    logic [3:0] lives_count;
    logic       hpLoss_trigger, LifeBonus, end_life, invulnerable, blink_visible;
`ifdef HIT_SHIELD_EN
    logic       shield_pickup;
    logic       shield_active;
`endif

    int   n_checks = 0;
    int   n_err    = 0;
    logic hp, lb, el;

    hit_event_generator dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .collision_enemy  (collision_enemy),
        .collision_bonus  (collision_bonus),
        .collision_lethal (collision_lethal),
        .lives_count      (lives_count),
        .hpLoss_trigger   (hpLoss_trigger),
        .LifeBonus        (LifeBonus),
        .end_life         (end_life),
        .invulnerable     (invulnerable),
        .blink_visible    (blink_visible)
`ifdef HIT_SHIELD_EN
        ,
        .shield_pickup    (shield_pickup),
        .shield_active    (shield_active)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
    endtask

    // Drives one frame with ne/nb/nl flag cycles, then startOfFrame; captures pulses 1 clk later.
    task automatic run_frame(input int ne, input int nb, input int nl, input logic [3:0] lives);
        int len;
        len = ne;
        if (nb > len) len = nb;
        if (nl > len) len = nl;
        len += 2;
        for (int i = 0; i < len; i++) begin
            collision_enemy  = (i < ne);
            collision_bonus  = (i < nb);
            collision_lethal = (i < nl);
            @(posedge clk); #1;
        end
        collision_enemy  = 1'b0;
        collision_bonus  = 1'b0;
        collision_lethal = 1'b0;
        lives_count      = lives;
        startOfFrame     = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        hp = hpLoss_trigger;
        lb = LifeBonus;
        el = end_life;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0;
        collision_enemy = 1'b0; collision_bonus = 1'b0; collision_lethal = 1'b0;
        lives_count = 4'd3;
`ifdef HIT_SHIELD_EN
        shield_pickup = 1'b0;
`endif
        do_reset();
        check("rst_hp",    hpLoss_trigger, 0);
        check("rst_lb",    LifeBonus, 0);
        check("rst_el",    end_life, 0);
        check("rst_inv",   invulnerable, 0);
        check("rst_blink", blink_visible, 1);

        // MIN_PIXELS-1 does not qualify
        run_frame(3, 0, 0, 3);
        check("below_min_hp",  hp, 0);
        check("below_min_inv", invulnerable, 0);

        // Exactly MIN_PIXELS qualifies
        run_frame(4, 0, 0, 3);
        check("hit_hp",    hp, 1);
        check("hit_inv",   invulnerable, 1);
        check("hit_blink", blink_visible, 0);
        @(posedge clk); #1;
        check("hit_width", hpLoss_trigger, 0);

        // 60 cooldown frames with enemy contact: no pulses, blink toggles every 4 frames
        for (int k = 1; k <= 60; k++) begin
            run_frame(6, 0, 0, 3);
            check("cd_hp",    hp, 0);
            check("cd_inv",   invulnerable, (k < 60) ? 1 : 0);
            check("cd_blink", blink_visible, (k == 60) ? 1 : ((k / 4) % 2));
        end
        // Frame 61 after entry: eligible again
        run_frame(10, 0, 0, 3);
        check("f61_hp",  hp, 1);
        check("f61_inv", invulnerable, 1);

        // Reset mid-cooldown
        do_reset();
        check("rstcd_inv",   invulnerable, 0);
        check("rstcd_blink", blink_visible, 1);

        // Reset mid-pulse: no residual pulse, back to ARMED
        run_frame(5, 0, 0, 3);
        check("mp_hp", hp, 1);
        resetN = 1'b0;
        #1;
        check("mp_gated", hpLoss_trigger, 0);
        @(posedge clk); #1;
        resetN = 1'b1;
        check("mp_inv", invulnerable, 0);
        check("mp_hp2", hpLoss_trigger, 0);

        // Saturation: 300 enemy cycles give a single pulse
        run_frame(300, 0, 0, 3);
        check("sat_hp", hp, 1);
        @(posedge clk); #1;
        check("sat_width", hpLoss_trigger, 0);
        do_reset();

        // Bonus gating on lives_count
        run_frame(0, 1, 0, 9);
        check("bonus_max_lb", lb, 0);
        run_frame(0, 1, 0, 3);
        check("bonus_3_lb", lb, 1);
        @(posedge clk); #1;
        check("bonus_width", LifeBonus, 0);
        run_frame(0, 5, 0, 8);
        check("bonus_8_lb", lb, 1);

        // Priority: lethal beats enemy and bonus; DEAD is terminal
        run_frame(10, 5, 1, 3);
        check("prio_el",    el, 1);
        check("prio_hp",    hp, 0);
        check("prio_lb",    lb, 0);
        check("dead_inv",   invulnerable, 0);
        check("dead_blink", blink_visible, 0);
        run_frame(10, 5, 0, 3);
        check("dead_hp", hp, 0);
        check("dead_lb", lb, 0);
        run_frame(0, 0, 2, 3);
        check("dead_el", el, 0);
        do_reset();
        check("dead_rst_blink", blink_visible, 1);

        // lives_count 0 at evaluation: DEAD with no pulse
        run_frame(0, 0, 0, 0);
        check("lives0_hp",    hp | lb | el, 0);
        check("lives0_blink", blink_visible, 0);
        run_frame(6, 0, 0, 3);
        check("lives0_after", hp, 0);
        do_reset();

        // Bonus and lethal during cooldown
        run_frame(4, 0, 0, 3);
        check("cd2_hp", hp, 1);
        run_frame(0, 2, 0, 3);
        check("cd_bonus_lb",  lb, 1);
        check("cd_bonus_inv", invulnerable, 1);
        run_frame(8, 0, 1, 3);
        check("cd_lethal_el",  el, 1);
        check("cd_lethal_hp",  hp, 0);
        check("cd_lethal_inv", invulnerable, 0);
        do_reset();

`ifdef HIT_SHIELD_EN
        check("sh_rst", shield_active, 0);
        shield_pickup = 1'b1;
        @(posedge clk); #1;
        shield_pickup = 1'b0;
        check("sh_set", shield_active, 1);
        run_frame(5, 0, 0, 3);
        check("sh_hp",  hp, 0);
        check("sh_clr", shield_active, 0);
        check("sh_inv", invulnerable, 1);
        for (int k = 1; k <= 60; k++) run_frame(0, 0, 0, 3);
        check("sh_armed", invulnerable, 0);
        run_frame(5, 0, 0, 3);
        check("sh_hit2", hp, 1);
        do_reset();
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
